// File: rtl/rf_write_port_arbiter_pkg.sv
// Shared types for the register-file write-port arbiter.
// FSM state encodings and the hard-wired-zero register index.
package rf_write_port_arbiter_pkg;

  typedef enum logic {
    ARB_NORMAL = 1'b0,
    ARB_FORCE  = 1'b1
  } arb_state_t;

  localparam int REG_X0 = 0;

endpackage

// File: rtl/rf_write_port_arbiter_if.sv
// Writeback / LLU / decode / register-file bundle for the write-port arbiter.
// The slave side is the arbiter; the master side drives requests.
interface rf_write_port_arbiter_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 5
);
  logic              arb_i_wb_valid;
  logic [AWIDTH-1:0] arb_i_wb_rd_addr;
  logic [DWIDTH-1:0] arb_i_wb_rd_data;
  logic              arb_o_wb_ready;
  logic              arb_i_llu_valid;
  logic [AWIDTH-1:0] arb_i_llu_rd_addr;
  logic [DWIDTH-1:0] arb_i_llu_rd_data;
  logic              arb_o_llu_ready;
  logic              arb_i_llu_issue;
  logic [AWIDTH-1:0] arb_i_issue_rd;
  logic [AWIDTH-1:0] arb_i_rs1_addr;
  logic [AWIDTH-1:0] arb_i_rs2_addr;
  logic [AWIDTH-1:0] arb_i_rd_addr;
  logic              arb_o_hazard;
  logic              arb_o_rf_we;
  logic [AWIDTH-1:0] arb_o_rf_addr;
  logic [DWIDTH-1:0] arb_o_rf_data;

  modport slave (
    input  arb_i_wb_valid, arb_i_wb_rd_addr, arb_i_wb_rd_data,
    output arb_o_wb_ready,
    input  arb_i_llu_valid, arb_i_llu_rd_addr, arb_i_llu_rd_data,
    output arb_o_llu_ready,
    input  arb_i_llu_issue, arb_i_issue_rd,
    input  arb_i_rs1_addr, arb_i_rs2_addr, arb_i_rd_addr,
    output arb_o_hazard,
    output arb_o_rf_we, arb_o_rf_addr, arb_o_rf_data
  );

  modport master (
    output arb_i_wb_valid, arb_i_wb_rd_addr, arb_i_wb_rd_data,
    input  arb_o_wb_ready,
    output arb_i_llu_valid, arb_i_llu_rd_addr, arb_i_llu_rd_data,
    input  arb_o_llu_ready,
    output arb_i_llu_issue, arb_i_issue_rd,
    output arb_i_rs1_addr, arb_i_rs2_addr, arb_i_rd_addr,
    input  arb_o_hazard,
    input  arb_o_rf_we, arb_o_rf_addr, arb_o_rf_data
  );
endinterface

// File: rtl/rf_scoreboard.sv
// Busy-bit scoreboard for LLU destinations; reports decode hazards.
// Hazard reads the registered busy vector, so a same-cycle clear is not bypassed.
module rf_scoreboard
  import rf_write_port_arbiter_pkg::*;
#(
  parameter int AWIDTH = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set_en,
  input  logic [AWIDTH-1:0] set_addr,
  input  logic              clr_en,
  input  logic [AWIDTH-1:0] clr_addr,
  input  logic [AWIDTH-1:0] rs1,
  input  logic [AWIDTH-1:0] rs2,
  input  logic [AWIDTH-1:0] rd,
  output logic              hazard
);
  localparam int NREG = 2**AWIDTH;

  logic [NREG-1:0] busy;
  logic [NREG-1:0] busy_n;

  always_comb begin
    busy_n = busy;
    if (clr_en) busy_n[clr_addr] = 1'b0;
    // set after clear so a re-issue to the same rd wins
    if (set_en) busy_n[set_addr] = 1'b1;
    busy_n[REG_X0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_n;
  end

  assign hazard = busy[rs1] | busy[rs2] | busy[rd];

endmodule

// File: rtl/rf_write_port_arbiter.sv
// Shares the register-file write port between WB and the long-latency unit.
// WB has priority; an aging counter forces an LLU grant so it never starves.
module rf_write_port_arbiter
  import rf_write_port_arbiter_pkg::*;
#(
  parameter int DWIDTH    = 32,
  parameter int AWIDTH    = 5,
  parameter int MAX_WAIT  = 4,
  parameter int CNT_WIDTH = 3
) (
  input logic                arb_clk,
  input logic                arb_rst,
  rf_write_port_arbiter_if.slave bus
);
  localparam logic [CNT_WIDTH-1:0] WAIT_LIM = CNT_WIDTH'(MAX_WAIT - 1);
  localparam logic [AWIDTH-1:0]    X0       = AWIDTH'(REG_X0);

  arb_state_t           state, state_n;
  logic [CNT_WIDTH-1:0] wait_cnt, wait_cnt_n;

  logic wb_wr, llu_wr;
  logic wb_ready, llu_ready;
  logic llu_acc, wb_gnt, llu_gnt;

  assign wb_wr  = bus.arb_i_wb_valid  && (bus.arb_i_wb_rd_addr  != X0);
  assign llu_wr = bus.arb_i_llu_valid && (bus.arb_i_llu_rd_addr != X0);

  always_comb begin
    wb_ready   = 1'b1;
    llu_ready  = 1'b0;
    state_n    = state;
    wait_cnt_n = wait_cnt;
    unique case (state)
      ARB_NORMAL: begin
        llu_ready = bus.arb_i_llu_valid && !(llu_wr && wb_wr);
        if (bus.arb_i_llu_valid && !llu_ready && wait_cnt >= WAIT_LIM)
          state_n = ARB_FORCE;
      end
      ARB_FORCE: begin
        llu_ready = bus.arb_i_llu_valid;
        wb_ready  = !(wb_wr && llu_wr);
        state_n   = ARB_NORMAL;
      end
      default: state_n = ARB_NORMAL;
    endcase
    if (bus.arb_i_llu_valid && llu_ready)
      wait_cnt_n = '0;
    else if (bus.arb_i_llu_valid && !llu_ready && wait_cnt != '1)
      wait_cnt_n = wait_cnt + 1'b1;
  end

  assign llu_acc = bus.arb_i_llu_valid && llu_ready;
  assign wb_gnt  = wb_wr && wb_ready;
  assign llu_gnt = llu_wr && llu_ready;

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      state    <= ARB_NORMAL;
      wait_cnt <= '0;
    end else begin
      state    <= state_n;
      wait_cnt <= wait_cnt_n;
    end
  end

  always_ff @(posedge arb_clk or posedge arb_rst) begin
    if (arb_rst) begin
      bus.arb_o_rf_we   <= 1'b0;
      bus.arb_o_rf_addr <= '0;
      bus.arb_o_rf_data <= '0;
    end else if (wb_gnt) begin
      bus.arb_o_rf_we   <= 1'b1;
      bus.arb_o_rf_addr <= bus.arb_i_wb_rd_addr;
      bus.arb_o_rf_data <= bus.arb_i_wb_rd_data;
    end else if (llu_gnt) begin
      bus.arb_o_rf_we   <= 1'b1;
      bus.arb_o_rf_addr <= bus.arb_i_llu_rd_addr;
      bus.arb_o_rf_data <= bus.arb_i_llu_rd_data;
    end else begin
      bus.arb_o_rf_we   <= 1'b0;
    end
  end

  assign bus.arb_o_wb_ready  = wb_ready;
  assign bus.arb_o_llu_ready = llu_ready;

  rf_scoreboard #(
    .AWIDTH (AWIDTH)
  ) u_sb (
    .clk      (arb_clk),
    .rst      (arb_rst),
    .set_en   (bus.arb_i_llu_issue),
    .set_addr (bus.arb_i_issue_rd),
    .clr_en   (llu_acc),
    .clr_addr (bus.arb_i_llu_rd_addr),
    .rs1      (bus.arb_i_rs1_addr),
    .rs2      (bus.arb_i_rs2_addr),
    .rd       (bus.arb_i_rd_addr),
    .hazard   (bus.arb_o_hazard)
  );

  unused_chk: assert property (@(posedge arb_clk) disable iff (arb_rst)
    !(wb_gnt && llu_gnt));

endmodule
